// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift sequencer.
package shift_pkg;

    // Operation encodings as issued by execute-stage control
    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    // Number of power-of-two stages walked per operation (log2 of datapath width)
    localparam int unsigned STAGES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_stage.sv
// One time-shared power-of-two shift/rotate stage; amount is 1 << amt_sel.
module shift_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    input  logic [1:0]       amt_sel,
    input  logic             en,
    output logic [WIDTH-1:0] out
);
    import shift_pkg::*;

    localparam int unsigned KW = $clog2(WIDTH) + 1;

    logic [KW-1:0]    k;
    logic [WIDTH-1:0] shifted;

    assign k = KW'(1) << amt_sel;

    // Select the shifted/rotated operand, or pass through when the stage bit is clear
    always_comb begin
        shifted = in;
        case (op)
            OP_ROL:  shifted = (in << k) | (in >> (WIDTH - k));
            OP_SLL:  shifted = in << k;
            OP_ROR:  shifted = (in >> k) | (in << (WIDTH - k));
            OP_SRL:  shifted = in >> k;
            default: shifted = in;
        endcase
        out = en ? shifted : in;
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer walking the shift count LSB-first, one power-of-two stage per cycle,
// with a start/busy/done handshake toward the pipeline.
module shift_seq_ctrl #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  in,
    input  logic [STAGES-1:0] cnt,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  out
);
    import shift_pkg::*;

    localparam logic [1:0] LAST_STAGE = 2'(STAGES - 1);

    state_t            state_q;
    logic [1:0]        stage_q;
    logic [1:0]        op_q;
    logic [STAGES-1:0] cnt_q;
    logic [WIDTH-1:0]  work_q;
    logic [WIDTH-1:0]  out_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  stage_d;

    shift_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .in      (work_q),
        .op      (op_q),
        .amt_sel (stage_q),
        .en      (cnt_q[stage_q]),
        .out     (stage_d)
    );

    // Controller FSM: operand capture, stage stepping, registered busy/done/out
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            work_q  <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        cnt_q   <= cnt;
                        work_q  <= in;
                        stage_q <= '0;
                        busy_q  <= 1'b1;
                        if (cnt != '0) begin
                            state_q <= SHIFT;
                        end else begin
                            // Zero count skips the stage walk entirely
                            state_q <= DONE;
                            out_q   <= in;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // Fixed latency: every stage is visited even when upper count bits are zero
                    work_q  <= stage_d;
                    stage_q <= stage_q + 2'd1;
                    if (stage_q == LAST_STAGE) begin
                        state_q <= DONE;
                        out_q   <= stage_d;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: table vectors, directed corner cases
// and an op x count sweep, with expected results queued at stimulus time.
module tb_shift_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] in_v;
    logic [3:0]  cnt;
    logic        busy;
    logic        done;
    logic [15:0] out_w;

    int unsigned n_vec;
    int unsigned n_bad;
    logic [15:0] sb[$];
    logic [15:0] last_out;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] din;
        logic [3:0]  cnt;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[10];

    shift_seq_ctrl #(
        .WIDTH  (16),
        .STAGES (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .in    (in_v),
        .cnt   (cnt),
        .busy  (busy),
        .done  (done),
        .out   (out_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] ref_model(input logic [1:0] o, input logic [15:0] d,
                                              input logic [3:0] c);
        logic [31:0] dbl;
        logic [15:0] r;
        dbl = {d, d};
        case (o)
            2'b00: begin dbl = dbl << c; r = dbl[31:16]; end
            2'b01: r = d << c;
            2'b10: begin dbl = dbl >> c; r = dbl[15:0]; end
            default: r = d >> c;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issue one operation, wait for done, verify latency, hold, busy, result and pulse width
    task automatic do_op(input logic [1:0] o, input logic [15:0] d, input logic [3:0] c,
                         input logic [15:0] exp);
        int unsigned n;
        logic [15:0] want;
        op    = o;
        in_v  = d;
        cnt   = c;
        start = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 2'($urandom);
        in_v  = 16'($urandom);
        cnt   = 4'($urandom);
        n = 1;
        while (!done && n < 12) begin
            check("busy_during_op", {31'b0, busy}, 32'd1);
            check("out_held", {16'b0, out_w}, {16'b0, last_out});
            @(posedge clk);
            #1;
            n++;
        end
        want = sb.pop_front();
        if (!done) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", n, (c == 4'd0) ? 32'd1 : 32'd5);
            check("busy_at_done", {31'b0, busy}, 32'd1);
            check("result", {16'b0, out_w}, {16'b0, want});
            last_out = want;
            @(posedge clk);
            #1;
            check("done_width", {31'b0, done}, 32'd0);
            check("busy_after", {31'b0, busy}, 32'd0);
            check("out_hold_after", {16'b0, out_w}, {16'b0, last_out});
        end
    endtask

    initial begin
        logic extra_done;
        int unsigned n;

        n_vec    = 0;
        n_bad    = 0;
        last_out = 16'h0000;

        tbl[0] = '{op: 2'b01, din: 16'h00FF, cnt: 4'd8,  exp: 16'hFF00};
        tbl[1] = '{op: 2'b11, din: 16'h8001, cnt: 4'd15, exp: 16'h0001};
        tbl[2] = '{op: 2'b00, din: 16'h8001, cnt: 4'd4,  exp: 16'h0018};
        tbl[3] = '{op: 2'b10, din: 16'h0001, cnt: 4'd1,  exp: 16'h8000};
        tbl[4] = '{op: 2'b00, din: 16'hA5A5, cnt: 4'd0,  exp: 16'hA5A5};
        tbl[5] = '{op: 2'b01, din: 16'h1234, cnt: 4'd3,  exp: 16'h91A0};
        tbl[6] = '{op: 2'b10, din: 16'h1234, cnt: 4'd4,  exp: 16'h4123};
        tbl[7] = '{op: 2'b11, din: 16'hF000, cnt: 4'd12, exp: 16'h000F};
        tbl[8] = '{op: 2'b00, din: 16'h1234, cnt: 4'd7,  exp: 16'h1A09};
        tbl[9] = '{op: 2'b10, din: 16'h8000, cnt: 4'd15, exp: 16'h0001};

        rst   = 1'b1;
        start = 1'b1;
        op    = 2'b01;
        in_v  = 16'hFFFF;
        cnt   = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out",  {16'b0, out_w}, 32'd0);
        check("reset_busy", {31'b0, busy},  32'd0);
        check("reset_done", {31'b0, done},  32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", {31'b0, busy}, 32'd0);

        // Table vectors
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].op, tbl[i].din, tbl[i].cnt, tbl[i].exp);
        end

        // A start pulse during SHIFT must be ignored
        op    = 2'b01;
        in_v  = 16'h1234;
        cnt   = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        in_v  = 16'hFFFF;
        cnt   = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 4;
        while (!done && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ign_done_seen", {31'b0, done}, 32'd1);
        check("ign_latency", n, 32'd5);
        check("ign_result", {16'b0, out_w}, 32'h91A0);
        last_out = 16'h91A0;
        extra_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) extra_done = 1'b1;
        end
        check("ign_no_second_done", {31'b0, extra_done}, 32'd0);
        check("ign_out_hold", {16'b0, out_w}, 32'h91A0);

        // Reset during the third SHIFT cycle aborts the operation
        op    = 2'b11;
        in_v  = 16'hF000;
        cnt   = 4'd12;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_out",  {16'b0, out_w}, 32'd0);
        check("abort_busy", {31'b0, busy},  32'd0);
        check("abort_done", {31'b0, done},  32'd0);
        last_out = 16'h0000;
        @(posedge clk);
        #1;
        check("abort_idle_busy", {31'b0, busy}, 32'd0);
        do_op(2'b11, 16'hF000, 4'd12, 16'h000F);

        // Sweep every op and count with random operands
        for (int o = 0; o < 4; o++) begin
            for (int c = 0; c < 16; c++) begin
                logic [15:0] d;
                d = 16'($urandom);
                do_op(2'(o), d, 4'(c), ref_model(2'(o), d, 4'(c)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
